// File: rtl/sig_reg_pkg.sv
// Shared constants for the signal-generator register group: address map, field widths,
// read-port state encoding and the default identification word.
package sig_reg_pkg;

  localparam int ADDR_W     = 4;
  localparam int CTRL_W     = 3;
  localparam int WAVE_W     = 2;
  localparam int AMPL_W     = 16;
  localparam int BUS_DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_FREQ   = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_PHASE  = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_AMPL   = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_COMMIT = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_ID     = 4'h6;
  localparam logic [ADDR_W-1:0] ADDR_WRCNT  = 4'hF;

  localparam logic [BUS_DATA_W-1:0] DEFAULT_ID = 32'h5347_0001;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/IModBus.sv
// Configurator link: independent write (address + data, acknowledged by wready)
// and read (address, then held data until rready) channels.
interface IModBus #(
  parameter int ADRR_SIZE = 4,
  parameter int DATA_SIZE = 32
);

  logic                 awvalid;
  logic [ADRR_SIZE-1:0] waddr;
  logic                 dwvalid;
  logic [DATA_SIZE-1:0] wdata;
  logic                 wready;
  logic                 arvalid;
  logic [ADRR_SIZE-1:0] raddr;
  logic                 drvalid;
  logic [DATA_SIZE-1:0] rdata;
  logic                 rready;

  modport master (
    output awvalid, waddr, dwvalid, wdata, arvalid, raddr, rready,
    input  wready, drvalid, rdata
  );

  modport slave (
    input  awvalid, waddr, dwvalid, wdata, arvalid, raddr, rready,
    output wready, drvalid, rdata
  );

endinterface

// File: rtl/sig_reg_rd_port.sv
// Read side of the register group: address mux plus a two-state FSM that captures
// the addressed value and holds it with drvalid until the master takes it.
module sig_reg_rd_port
  import sig_reg_pkg::*;
#(
  parameter int                    DATA_SIZE = 32,
  parameter logic [BUS_DATA_W-1:0] ID_VALUE  = DEFAULT_ID
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arvalid,
  input  logic [ADDR_W-1:0]    raddr,
  input  logic                 rready,
  input  logic [CTRL_W-1:0]    ctrl_sh,
  input  logic [DATA_SIZE-1:0] freq_sh,
  input  logic [DATA_SIZE-1:0] phase_sh,
  input  logic [AMPL_W-1:0]    ampl_sh,
  input  logic [DATA_SIZE-1:0] status,
`ifdef SIG_REG_WRCNT_EN
  input  logic [DATA_SIZE-1:0] wrcnt,
`endif
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 drvalid
);

  rd_state_t            state, state_nxt;
  logic [DATA_SIZE-1:0] rd_mux;
  logic [DATA_SIZE-1:0] rdata_nxt;
  logic                 drvalid_nxt;

  // Shadows read back, not the committed copies; COMMIT and holes read 0
  always_comb begin
    rd_mux = '0;
    case (raddr)
      ADDR_CTRL:   rd_mux = DATA_SIZE'(ctrl_sh);
      ADDR_FREQ:   rd_mux = freq_sh;
      ADDR_PHASE:  rd_mux = phase_sh;
      ADDR_AMPL:   rd_mux = DATA_SIZE'(ampl_sh);
      ADDR_STATUS: rd_mux = status;
      ADDR_ID:     rd_mux = DATA_SIZE'(ID_VALUE);
`ifdef SIG_REG_WRCNT_EN
      ADDR_WRCNT:  rd_mux = wrcnt;
`endif
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= R_IDLE;
      rdata   <= '0;
      drvalid <= 1'b0;
    end else begin
      state   <= state_nxt;
      rdata   <= rdata_nxt;
      drvalid <= drvalid_nxt;
    end
  end

  // arvalid is only looked at in R_IDLE, so a held response cannot be overwritten
  always_comb begin
    state_nxt   = state;
    rdata_nxt   = rdata;
    drvalid_nxt = drvalid;
    case (state)
      R_IDLE: begin
        if (arvalid) begin
          state_nxt   = R_DATA;
          rdata_nxt   = rd_mux;
          drvalid_nxt = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          state_nxt   = R_IDLE;
          drvalid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = R_IDLE;
        drvalid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sig_reg_group.sv
// Signal-generator configuration registers: shadow registers written over IModBus,
// copied to the active outputs on a COMMIT write. SIG_REG_WRCNT_EN adds WRCNT at 0xF.
module sig_reg_group
  import sig_reg_pkg::*;
#(
  parameter logic [BUS_DATA_W-1:0] ID_VALUE  = DEFAULT_ID,
  parameter int                    DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  IModBus.slave                bus,
  input  logic [DATA_SIZE-1:0] status_in,
  output logic                 ctrl_enable,
  output logic [WAVE_W-1:0]    wave_sel,
  output logic [DATA_SIZE-1:0] freq_word,
  output logic [DATA_SIZE-1:0] phase_word,
  output logic [AMPL_W-1:0]    ampl,
  output logic                 cfg_update
);

  logic                 aw_held, dw_held;
  logic [ADDR_W-1:0]    waddr_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic                 wready_q;
  logic                 fire;

  logic [CTRL_W-1:0]    ctrl_sh, ctrl_act;
  logic [DATA_SIZE-1:0] freq_sh, phase_sh;
  logic [AMPL_W-1:0]    ampl_sh;

  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_valid;

  assign fire = aw_held & dw_held;

  // Address and data are captured independently; the write fires once both are held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      dw_held  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wready_q <= 1'b0;
    end else begin
      wready_q <= fire;
      if (fire) begin
        aw_held <= 1'b0;
        dw_held <= 1'b0;
      end else begin
        if (!aw_held && bus.awvalid) begin
          aw_held <= 1'b1;
          waddr_q <= bus.waddr;
        end
        if (!dw_held && bus.dwvalid) begin
          dw_held <= 1'b1;
          wdata_q <= bus.wdata;
        end
      end
    end
  end

  // Register update lands on the same edge that raises wready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_sh    <= '0;
      freq_sh    <= '0;
      phase_sh   <= '0;
      ampl_sh    <= '0;
      ctrl_act   <= '0;
      freq_word  <= '0;
      phase_word <= '0;
      ampl       <= '0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      if (fire) begin
        case (waddr_q)
          ADDR_CTRL:  ctrl_sh  <= wdata_q[CTRL_W-1:0];
          ADDR_FREQ:  freq_sh  <= wdata_q;
          ADDR_PHASE: phase_sh <= wdata_q;
          ADDR_AMPL:  ampl_sh  <= wdata_q[AMPL_W-1:0];
          ADDR_COMMIT: begin
            ctrl_act   <= ctrl_sh;
            freq_word  <= freq_sh;
            phase_word <= phase_sh;
            ampl       <= ampl_sh;
            cfg_update <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ctrl_enable = ctrl_act[0];
  assign wave_sel    = ctrl_act[CTRL_W-1:1];

`ifdef SIG_REG_WRCNT_EN
  logic [DATA_SIZE-1:0] wrcnt;

  // A write to WRCNT clears it instead of counting itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrcnt <= '0;
    end else if (fire) begin
      if (waddr_q == ADDR_WRCNT) wrcnt <= '0;
      else                       wrcnt <= wrcnt + DATA_SIZE'(1);
    end
  end
`endif

  sig_reg_rd_port #(
    .DATA_SIZE (DATA_SIZE),
    .ID_VALUE  (ID_VALUE)
  ) u_rd_port (
    .clk      (clk),
    .rst      (rst),
    .arvalid  (bus.arvalid),
    .raddr    (bus.raddr),
    .rready   (bus.rready),
    .ctrl_sh  (ctrl_sh),
    .freq_sh  (freq_sh),
    .phase_sh (phase_sh),
    .ampl_sh  (ampl_sh),
    .status   (status_in),
`ifdef SIG_REG_WRCNT_EN
    .wrcnt    (wrcnt),
`endif
    .rdata    (rd_data),
    .drvalid  (rd_valid)
  );

  assign bus.wready  = wready_q;
  assign bus.rdata   = rd_data;
  assign bus.drvalid = rd_valid;

endmodule

// File: tb/tb_sig_reg_group.sv
// Directed bench for sig_reg_group: write handshake timing, commit, readback,
// held read response, mid-transaction reset and the optional write counter.
module tb_sig_reg_group;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] status_in = 32'h0;
  logic        ctrl_enable;
  logic [1:0]  wave_sel;
  logic [31:0] freq_word;
  logic [31:0] phase_word;
  logic [15:0] ampl;
  logic        cfg_update;

  int n_checks = 0;
  int n_fail   = 0;

  IModBus #(.ADRR_SIZE(4), .DATA_SIZE(32)) bus ();

  sig_reg_group #(.ID_VALUE(32'h5347_0001), .DATA_SIZE(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .status_in   (status_in),
    .ctrl_enable (ctrl_enable),
    .wave_sel    (wave_sel),
    .freq_word   (freq_word),
    .phase_word  (phase_word),
    .ampl        (ampl),
    .cfg_update  (cfg_update)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    int k;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.waddr = a; bus.dwvalid = 1'b1; bus.wdata = d;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.dwvalid = 1'b0;
    k = 0;
    while (bus.wready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.wready !== 1'b1) begin
      n_fail++; $display("FAIL write_ack addr=%h: wready=%b, required 1", a, bus.wready);
    end
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    int k;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.raddr = a; bus.rready = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    k = 0;
    while (bus.drvalid !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (bus.drvalid !== 1'b1) begin
      n_fail++; $display("FAIL read_valid addr=%h: drvalid=%b, required 1", a, bus.drvalid);
    end
    d = bus.rdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.awvalid = 1'b0; bus.dwvalid = 1'b0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.waddr = 4'h0; bus.wdata = 32'h0; bus.raddr = 4'h0;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready: got %b, required 0", bus.wready); end
    n_checks++;
    if (bus.drvalid !== 1'b0) begin n_fail++; $display("FAIL reset_drvalid: got %b, required 0", bus.drvalid); end
    n_checks++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, required 0", bus.rdata); end
    n_checks++;
    if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_update: got %b, required 0", cfg_update); end
    n_checks++;
    if ({ctrl_enable, wave_sel, ampl} !== 19'h0) begin
      n_fail++; $display("FAIL reset_ctrl_ampl: got %b/%b/%h, required 0", ctrl_enable, wave_sel, ampl);
    end
    n_checks++;
    if ({freq_word, phase_word} !== 64'h0) begin
      n_fail++; $display("FAIL reset_freq_phase: got %h/%h, required 0", freq_word, phase_word);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_same_cycle();
    logic [31:0] r;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.waddr = 4'h1; bus.dwvalid = 1'b1; bus.wdata = 32'h0001_0000;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.dwvalid = 1'b0;
    n_checks++;
    if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL same_cycle_early: wready=%b, required 0", bus.wready); end
    @(negedge clk);
    n_checks++;
    if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_wready: wready=%b, required 1", bus.wready); end
    n_checks++;
    if (freq_word !== 32'h0) begin n_fail++; $display("FAIL same_cycle_active: freq_word=%h, required 0", freq_word); end
    @(negedge clk);
    n_checks++;
    if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pulse: wready=%b, required 0", bus.wready); end
    do_read(4'h1, r);
    n_checks++;
    if (r !== 32'h0001_0000) begin n_fail++; $display("FAIL same_cycle_readback: got %h, required 00010000", r); end
  endtask

  task automatic test_addr_first();
    logic [31:0] r;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.waddr = 4'h0; bus.wdata = 32'hFFFF_FFFD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.awvalid = 1'b0;
      n_checks++;
      if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL addr_first_wait%0d: wready=%b, required 0", i, bus.wready); end
    end
    bus.dwvalid = 1'b1;
    @(negedge clk);
    bus.dwvalid = 1'b0;
    n_checks++;
    if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL addr_first_early: wready=%b, required 0", bus.wready); end
    @(negedge clk);
    n_checks++;
    if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL addr_first_wready: wready=%b, required 1", bus.wready); end
    do_read(4'h0, r);
    n_checks++;
    if (r !== 32'h0000_0005) begin n_fail++; $display("FAIL addr_first_ctrl: got %h, required 00000005", r); end
    n_checks++;
    if (ctrl_enable !== 1'b0) begin n_fail++; $display("FAIL addr_first_active: ctrl_enable=%b, required 0", ctrl_enable); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    @(negedge clk);
    bus.dwvalid = 1'b1; bus.wdata = 32'h0000_2222;
    @(negedge clk);
    bus.dwvalid = 1'b0; bus.awvalid = 1'b1; bus.waddr = 4'h2;
    @(negedge clk);
    bus.awvalid = 1'b0;
    n_checks++;
    if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL data_first_early: wready=%b, required 0", bus.wready); end
    @(negedge clk);
    n_checks++;
    if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL data_first_wready: wready=%b, required 1", bus.wready); end
    do_read(4'h2, r);
    n_checks++;
    if (r !== 32'h0000_2222) begin n_fail++; $display("FAIL data_first_phase: got %h, required 00002222", r); end
    // valids kept high through the wready cycle start a second transaction
    @(negedge clk);
    bus.awvalid = 1'b1; bus.waddr = 4'h2; bus.dwvalid = 1'b1; bus.wdata = 32'hAAAA_0001;
    @(negedge clk);
    n_checks++;
    if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL b2b_first_early: wready=%b, required 0", bus.wready); end
    @(negedge clk);
    n_checks++;
    if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_wready: wready=%b, required 1", bus.wready); end
    bus.wdata = 32'hBBBB_0002;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.dwvalid = 1'b0;
    n_checks++;
    if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: wready=%b, required 0", bus.wready); end
    @(negedge clk);
    n_checks++;
    if (bus.wready !== 1'b1) begin n_fail++; $display("FAIL b2b_second_wready: wready=%b, required 1", bus.wready); end
    @(negedge clk);
    n_checks++;
    if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL b2b_no_third: wready=%b, required 0", bus.wready); end
    do_read(4'h2, r);
    n_checks++;
    if (r !== 32'hBBBB_0002) begin n_fail++; $display("FAIL b2b_phase: got %h, required bbbb0002", r); end
  endtask

  task automatic test_commit();
    logic [31:0] r;
    do_write(4'h0, 32'hFFFF_FFFB);
    do_write(4'h3, 32'hABCD_1234);
    n_checks++;
    if ({ctrl_enable, wave_sel, ampl} !== 19'h0) begin
      n_fail++; $display("FAIL commit_pre_active: got %b/%b/%h, required 0", ctrl_enable, wave_sel, ampl);
    end
    do_read(4'h3, r);
    n_checks++;
    if (r !== 32'h0000_1234) begin n_fail++; $display("FAIL commit_ampl_mask: got %h, required 00001234", r); end
    do_read(4'h0, r);
    n_checks++;
    if (r !== 32'h0000_0003) begin n_fail++; $display("FAIL commit_ctrl_mask: got %h, required 00000003", r); end
    @(negedge clk);
    bus.awvalid = 1'b1; bus.waddr = 4'h4; bus.dwvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.dwvalid = 1'b0;
    n_checks++;
    if (cfg_update !== 1'b0) begin n_fail++; $display("FAIL commit_early: cfg_update=%b, required 0", cfg_update); end
    @(negedge clk);
    n_checks++;
    if ({cfg_update, bus.wready} !== 2'b11) begin
      n_fail++; $display("FAIL commit_pulse: cfg_update/wready=%b%b, required 11", cfg_update, bus.wready);
    end
    n_checks++;
    if ({ctrl_enable, wave_sel, ampl} !== {1'b1, 2'b01, 16'h1234}) begin
      n_fail++; $display("FAIL commit_outputs: got %b/%b/%h, required 1/01/1234", ctrl_enable, wave_sel, ampl);
    end
    n_checks++;
    if ({freq_word, phase_word} !== {32'h0001_0000, 32'hBBBB_0002}) begin
      n_fail++; $display("FAIL commit_words: got %h/%h, required 00010000/bbbb0002", freq_word, phase_word);
    end
    @(negedge clk);
    n_checks++;
    if ({cfg_update, ctrl_enable} !== 2'b01) begin
      n_fail++; $display("FAIL commit_after: cfg_update/ctrl_enable=%b%b, required 01", cfg_update, ctrl_enable);
    end
    do_read(4'h4, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL commit_reads_zero: got %h, required 0", r); end
    do_write(4'h1, 32'h1111_2222);
    n_checks++;
    if (freq_word !== 32'h0001_0000) begin n_fail++; $display("FAIL shadow_only: freq_word=%h, required 00010000", freq_word); end
  endtask

  task automatic test_read_only();
    logic [31:0] r;
    status_in = 32'hCAFE_F00D;
    do_read(4'h5, r);
    n_checks++;
    if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL status_read: got %h, required cafef00d", r); end
    do_write(4'h5, 32'h0000_1234);
    do_write(4'h6, 32'h0000_0000);
    do_read(4'h6, r);
    n_checks++;
    if (r !== 32'h5347_0001) begin n_fail++; $display("FAIL id_read: got %h, required 53470001", r); end
    do_read(4'h5, r);
    n_checks++;
    if (r !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL status_after_write: got %h, required cafef00d", r); end
    do_write(4'h9, 32'hFFFF_FFFF);
    do_read(4'h9, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h, required 0", r); end
  endtask

  task automatic test_read_hold();
    @(negedge clk);
    bus.arvalid = 1'b1; bus.raddr = 4'h6; bus.rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.raddr = 4'h5;
      n_checks++;
      if (bus.drvalid !== 1'b1 || bus.rdata !== 32'h5347_0001) begin
        n_fail++; $display("FAIL read_hold%0d: drvalid=%b rdata=%h, required 1/53470001", i, bus.drvalid, bus.rdata);
      end
    end
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.drvalid !== 1'b0) begin n_fail++; $display("FAIL read_release: drvalid=%b, required 0", bus.drvalid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.waddr = 4'h0; bus.dwvalid = 1'b1; bus.wdata = 32'h0000_0007;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.dwvalid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.wready, cfg_update, ctrl_enable} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_outputs: wready/cfg/en=%b%b%b, required 000", bus.wready, cfg_update, ctrl_enable);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.wready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_ack%0d: wready=%b, required 0", i, bus.wready); end
    end
    do_read(4'h0, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %h, required 0", r); end
    do_write(4'h2, 32'h0BAD_F00D);
    do_read(4'h2, r);
    n_checks++;
    if (r !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rst_mid_bus_alive: got %h, required 0badf00d", r); end
  endtask

  task automatic test_wrcnt();
    logic [31:0] r;
`ifdef SIG_REG_WRCNT_EN
    do_write(4'hF, 32'h0000_0055);
    do_read(4'hF, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL wrcnt_clear0: got %h, required 0", r); end
    do_write(4'h1, 32'h1);
    do_write(4'h2, 32'h2);
    do_write(4'h9, 32'h3);
    do_read(4'hF, r);
    n_checks++;
    if (r !== 32'h3) begin n_fail++; $display("FAIL wrcnt_three: got %h, required 3", r); end
    do_write(4'hF, 32'hFFFF_FFFF);
    do_read(4'hF, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL wrcnt_clear: got %h, required 0", r); end
`else
    do_write(4'hF, 32'h0000_0055);
    do_read(4'hF, r);
    n_checks++;
    if (r !== 32'h0) begin n_fail++; $display("FAIL reserved_0f: got %h, required 0", r); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_addr_first();
    test_back_to_back();
    test_commit();
    test_read_only();
    test_read_hold();
    test_reset_mid();
    test_wrcnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sig_reg_group.md
SIG_REG_GROUP -- requirements
Module: sig_reg_group

Interface
REQ-001 The block SHALL have parameter ID_VALUE, default 32'h5347_0001, the constant returned at address 0x6.
REQ-002 The block SHALL have parameter DATA_SIZE, default 32, the register width, equal to the bus data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port bus, IModBus slave modport, ADRR_SIZE=4 and DATA_SIZE=32: the configurator link.
REQ-006 The block SHALL have port status_in, input, 32 bits: live status, readable at 0x5.
REQ-007 The block SHALL have port ctrl_enable, output, 1 bit: active CTRL[0].
REQ-008 The block SHALL have port wave_sel, output, 2 bits: active CTRL[2:1].
REQ-009 The block SHALL have port freq_word, output, 32 bits: active FREQ.
REQ-010 The block SHALL have port phase_word, output, 32 bits: active PHASE.
REQ-011 The block SHALL have port ampl, output, 16 bits: active AMPL[15:0].
REQ-012 The block SHALL have port cfg_update, output, 1 bit: one-cycle pulse on commit.

Function
REQ-013 Register map SHALL be: 0x0 CTRL, 0x1 FREQ, 0x2 PHASE and 0x3 AMPL as RW shadows; 0x4 COMMIT as write-only, reads 0; 0x5 STATUS as read-only; 0x6 ID as read-only; 0x7-0xF reserved.
REQ-014 Write path SHALL latch waddr on any cycle awvalid=1 with the address not yet held, and wdata on any cycle dwvalid=1 with the data not yet held; either order or the same cycle is legal.
REQ-015 On the cycle after both are held, the block SHALL perform the write and assert wready for exactly one cycle, then clear both held flags.
REQ-016 Master valids still high on the cycle after wready SHALL be latched as a new transaction, because the master must drop them on wready.
REQ-017 Writes to shadows SHALL store the masked width (CTRL 3 bits, AMPL 16 bits, others 32); writes to 0x5, 0x6 and reserved addresses SHALL be discarded but still SHALL produce wready.
REQ-018 A write to 0x4 with any data SHALL copy all shadows to active outputs and pulse cfg_update in the cycle wready is high, with outputs updating on the same edge.
REQ-019 Outputs SHALL change only on a commit; shadow writes alone SHALL NOT affect them.
REQ-020 The read FSM SHALL be R_IDLE -> R_DATA when arvalid=1; that edge registers rdata from the addressed location and sets drvalid=1.
REQ-021 In R_DATA, rdata and drvalid SHALL hold until rready=1, then drvalid=0 at the next edge and the FSM SHALL return to R_IDLE; arvalid SHALL be ignored in R_DATA.
REQ-022 Shadow registers SHALL read back shadow, not active, values; reserved addresses and COMMIT SHALL read 0.
REQ-023 Read and write paths SHALL be independent; a read latched on the same edge as a write to the same address SHALL return the pre-write value.

Reset
REQ-024 While rst=1, asynchronously: all shadows and actives SHALL be 0, wready=0, drvalid=0, rdata=0 and cfg_update=0; held flags SHALL clear and the FSM SHALL be in R_IDLE.
REQ-025 Reset mid-transaction SHALL abort the transaction with no register update and no pulse.

Configuration
REQ-026 With SIG_REG_WRCNT_EN defined, address 0xF SHALL be WRCNT: a 32-bit count of wready pulses that wraps at 2^32 and is reset to 0.
REQ-027 With SIG_REG_WRCNT_EN defined, a write to 0xF SHALL clear WRCNT to 0; that write itself SHALL NOT be counted.
REQ-028 Without SIG_REG_WRCNT_EN, 0xF SHALL be reserved and no counter logic SHALL exist.

Structure
REQ-029 Package sig_reg_pkg SHALL hold the address localparams, field widths, the read FSM enum and the default ID.
REQ-030 The read FSM and mux SHALL be a single sub-module, sig_reg_rd_port; the write path and registers SHALL stay in the top.

Verification
REQ-031 Write FREQ=32'h0001_0000 with awvalid and dwvalid in the same cycle -> wready one cycle later; freq_word stays 0; a read of 0x1 returns 32'h0001_0000.
REQ-032 Address three cycles before data, then data -> wready exactly one cycle after data; CTRL=3'b101 is stored.
REQ-033 Write COMMIT after shadows CTRL=3'b011 and AMPL=16'h1234 -> cfg_update one pulse; ctrl_enable=1, wave_sel=2'b01, ampl=16'h1234 on the same edge.
REQ-034 Read 0x6 with rready held low for five cycles -> drvalid and rdata=32'h5347_0001 stable for all five; drvalid=0 one cycle after rready=1.
REQ-035 Assert rst between wdata latch and wready -> no wready, no register change; bus idle after release.
REQ-036 With SIG_REG_WRCNT_EN, three writes then read 0xF -> 3; write 0xF then read -> 0.
